// File: rtl/negedge_regfile_pkg.sv
// rtl/negedge_regfile_pkg.sv - shared constants and types for the negedge register file
package negedge_regfile_pkg;

  // Largest supported entry count; bounds the pending vector type.
  localparam int MAX_DEPTH = 32;

  // When reserve and clear hit one entry on the same edge, the new producer wins.
  localparam bit RSV_OVER_CLR = 1'b1;

  // Pending vector sized for the largest configuration.
  typedef logic [MAX_DEPTH-1:0] pend_vec_t;

  // Index width for a given entry count.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/negedge_reg_entry.sv
// rtl/negedge_reg_entry.sv - one data register plus scoreboard pending flop, falling-edge clocked
module negedge_reg_entry
  import negedge_regfile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             set,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             pend,
  output logic             pend_nxt
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             pend_q, pend_d;

  // Next data and pending state; a same-edge set and clear resolves to the reserve.
  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    if (load) data_d = din;
    if (set && clr) pend_d = RSV_OVER_CLR;
    else if (set)   pend_d = 1'b1;
    else if (clr)   pend_d = 1'b0;
  end

  // Capture on the falling edge so same-cycle posedge consumers see the new state.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  assign dout     = data_q;
  assign pend     = pend_q;
  assign pend_nxt = pend_d;

endmodule

// File: rtl/negedge_regfile_sb.sv
// rtl/negedge_regfile_sb.sv - negedge register file with per-entry hazard scoreboard
module negedge_regfile_sb
  import negedge_regfile_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             we,
  input  logic [addr_w(DEPTH)-1:0]         waddr,
  input  logic [WIDTH-1:0]                 wdata,
  input  logic                             wclr,
  input  logic                             rsv,
  input  logic [addr_w(DEPTH)-1:0]         rsv_addr,
  input  logic [NUM_RD*addr_w(DEPTH)-1:0]  raddr,
  output logic [NUM_RD*WIDTH-1:0]          rdata,
  output logic [NUM_RD-1:0]                rpend,
  output logic                             any_pend,
  output logic [addr_w(DEPTH):0]           pend_cnt
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] data_arr [DEPTH];
  logic [DEPTH-1:0] pend_vec;
  logic [DEPTH-1:0] pend_next;
  logic [CW-1:0]    pend_cnt_q, pend_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(gi);
      if (ZERO_REG && gi == 0) begin : g_zero
        // Hardwired zero entry: no storage, never pends.
        assign data_arr[gi]  = '0;
        assign pend_vec[gi]  = 1'b0;
        assign pend_next[gi] = 1'b0;
      end else begin : g_reg
        negedge_reg_entry #(.WIDTH(WIDTH)) u_entry (
          .clk      (clk),
          .rst_n    (rst_n),
          .load     (we && (waddr == IDX)),
          .din      (wdata),
          .set      (rsv && (rsv_addr == IDX)),
          .clr      (we && wclr && (waddr == IDX)),
          .dout     (data_arr[gi]),
          .pend     (pend_vec[gi]),
          .pend_nxt (pend_next[gi])
        );
      end
    end
  endgenerate

  // Independent combinational read ports straight from stored state.
  always_comb begin
    rdata = '0;
    rpend = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rdata[p*WIDTH +: WIDTH] = data_arr[raddr[p*AW +: AW]];
      rpend[p]                = pend_vec[raddr[p*AW +: AW]];
    end
  end

  // Population count of the pending vector as it will be after this edge.
  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + CW'(pend_next[i]);
    end
  end

  // Registered count tracks the pending vector edge for edge.
  always_ff @(negedge clk) begin
    if (!rst_n) pend_cnt_q <= '0;
    else        pend_cnt_q <= pend_cnt_d;
  end

  assign any_pend = |pend_vec;
  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_negedge_regfile_sb.sv
// tb/tb_negedge_regfile_sb.sv - randomized self-checking bench for the negedge register file
module tb_negedge_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        wclr;
  logic        rsv;
  logic [2:0]  rsv_addr;
  logic [8:0]  raddr;
  logic [47:0] rdata_a;
  logic [2:0]  rpend_a;
  logic        any_pend_a;
  logic [3:0]  pend_cnt_a;
  logic [31:0] rdata_b;
  logic [1:0]  rpend_b;
  logic        any_pend_b;
  logic [3:0]  pend_cnt_b;

  int n_checks = 0;
  int n_errors = 0;
  bit model_valid = 1'b0;

  logic [15:0] mem_a [8];
  bit          pnd_a [8];
  logic [15:0] mem_b [8];
  bit          pnd_b [8];

  always #5 clk = ~clk;

  negedge_regfile_sb #(.WIDTH(16), .DEPTH(8), .NUM_RD(3), .ZERO_REG(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
    .rsv(rsv), .rsv_addr(rsv_addr), .raddr(raddr), .rdata(rdata_a), .rpend(rpend_a),
    .any_pend(any_pend_a), .pend_cnt(pend_cnt_a)
  );

  negedge_regfile_sb #(.WIDTH(16), .DEPTH(8), .NUM_RD(2), .ZERO_REG(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wclr(wclr),
    .rsv(rsv), .rsv_addr(rsv_addr), .raddr(raddr[5:0]), .rdata(rdata_b), .rpend(rpend_b),
    .any_pend(any_pend_b), .pend_cnt(pend_cnt_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int count_a();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(pnd_a[i]);
    return c;
  endfunction

  function automatic int count_b();
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(pnd_b[i]);
    return c;
  endfunction

  // Architectural rules: write data, clear on write, then reserve last so it wins.
  task automatic apply_model();
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] = '0; pnd_a[i] = 1'b0; mem_b[i] = '0; pnd_b[i] = 1'b0;
      end
    end else begin
      if (we) begin
        mem_a[waddr] = wdata;
        if (wclr) pnd_a[waddr] = 1'b0;
        if (waddr != 0) begin
          mem_b[waddr] = wdata;
          if (wclr) pnd_b[waddr] = 1'b0;
        end
      end
      if (rsv) begin
        pnd_a[rsv_addr] = 1'b1;
        if (rsv_addr != 0) pnd_b[rsv_addr] = 1'b1;
      end
    end
    model_valid = 1'b1;
  endtask

  task automatic check_all(input string ph);
    logic [2:0] ra;
    for (int p = 0; p < 3; p++) begin
      ra = raddr[p*3 +: 3];
      check_val($sformatf("%s_a_rdata%0d", ph, p), 32'(rdata_a[p*16 +: 16]), 32'(mem_a[ra]));
      check_val($sformatf("%s_a_rpend%0d", ph, p), 32'(rpend_a[p]), 32'(pnd_a[ra]));
    end
    for (int p = 0; p < 2; p++) begin
      ra = raddr[p*3 +: 3];
      check_val($sformatf("%s_b_rdata%0d", ph, p), 32'(rdata_b[p*16 +: 16]), 32'(mem_b[ra]));
      check_val($sformatf("%s_b_rpend%0d", ph, p), 32'(rpend_b[p]), 32'(pnd_b[ra]));
    end
    check_val({ph, "_a_pend_cnt"}, 32'(pend_cnt_a), 32'(count_a()));
    check_val({ph, "_a_any_pend"}, 32'(any_pend_a), 32'(count_a() != 0));
    check_val({ph, "_b_pend_cnt"}, 32'(pend_cnt_b), 32'(count_b()));
    check_val({ph, "_b_any_pend"}, 32'(any_pend_b), 32'(count_b() != 0));
  endtask

  // Inputs are already set after a posedge; check old state, capture, check new state.
  task automatic step();
    #1;
    if (model_valid) check_all("pre");
    @(negedge clk);
    apply_model();
    #1;
    check_all("post");
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit w, input int wa, input int wd, input bit c,
                       input bit s, input int sa, input int r0, input int r1, input int r2);
    rst_n = ~r; we = w; waddr = 3'(wa); wdata = 16'(wd); wclr = c;
    rsv = s; rsv_addr = 3'(sa); raddr = {3'(r2), 3'(r1), 3'(r0)};
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    // Reset wipes a written value.
    drive(0, 1, 3, 16'hBEEF, 0, 0, 0, 3, 3, 3); step();
    drive(1, 1, 3, 16'h1111, 0, 1, 3, 3, 0, 0); step();
    check_val("reset_data3", 32'(rdata_a[15:0]), 32'h0);
    check_val("reset_pend_cnt", 32'(pend_cnt_a), 32'h0);
    // Half-cycle write to entry 5.
    drive(0, 1, 5, 16'h1234, 0, 0, 0, 5, 0, 5); step();
    check_val("halfcyc_data5", 32'(rdata_a[15:0]), 32'h1234);
    // Scoreboard reserve and release.
    drive(0, 0, 0, 0, 0, 1, 2, 2, 4, 0); step();
    drive(0, 0, 0, 0, 0, 1, 4, 2, 4, 0); step();
    check_val("sb_pend_cnt2", 32'(pend_cnt_a), 32'd2);
    drive(0, 1, 2, 16'hAAAA, 1, 0, 0, 2, 4, 0); step();
    check_val("sb_release_cnt", 32'(pend_cnt_a), 32'd1);
    check_val("sb_release_data", 32'(rdata_a[15:0]), 32'hAAAA);
    // Same-index write+clear and reserve: reserve wins.
    drive(0, 0, 0, 0, 0, 1, 6, 6, 6, 0); step();
    drive(0, 1, 6, 16'h0F0F, 1, 1, 6, 6, 6, 0); step();
    check_val("collide_pend", 32'(rpend_a[0]), 32'h1);
    check_val("collide_cnt", 32'(pend_cnt_a), 32'd2);
    // Entry 0 in the hardwired-zero instance.
    drive(0, 1, 0, 16'hFFFF, 0, 1, 0, 0, 0, 0); step();
    check_val("zero_data", 32'(rdata_b[15:0]), 32'h0);
    check_val("zero_cnt", 32'(pend_cnt_b), 32'd2);
    // Multiport reads then reserve everything.
    drive(0, 1, 1, 16'h5A5A, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 7, 16'hC3C3, 0, 0, 0, 1, 1, 7); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 0, 1, i, 1, 1, 7); step();
    end
    check_val("all_pend_cnt", 32'(pend_cnt_a), 32'd8);
    check_val("all_any_pend", 32'(any_pend_a), 32'h1);
    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 65535)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0) rsv_addr = waddr;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
